// File: rtl/frame_padder_pkg.sv
// Shared types and derived-size helpers for the frame padder.
// PPW = pixels per output word, WORDS_PER_COL = output words per padded column.
package frame_padder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PAD_FIRST = 3'd1,
    BODY      = 3'd2,
    PAD_LAST  = 3'd3,
    DONE      = 3'd4
  } state_t;

  // PPW: how many pixels fit in one output word.
  function automatic int calc_ppw(input int nb_data, input int nb_pixel);
    return nb_data / nb_pixel;
  endfunction

  // WORDS_PER_COL: output words needed for one padded column.
  function automatic int calc_words_per_col(input int image_height, input int ppw);
    return image_height / ppw;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs pixels into words, lane 0 first; pad_vld emits a whole zero word instead.
// Latency: word registered one cycle after its last lane (or pad request).
// Backpressure: none, every request is taken the cycle it is presented.
module pixel_packer
  import frame_padder_pkg::*;
#(
  parameter int NB_PIXEL = 8,
  parameter int NB_DATA  = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                pix_vld,
  input  logic [NB_PIXEL-1:0] pix_dat,
  input  logic                pad_vld,
  output logic                word_vld,
  output logic [NB_DATA-1:0]  word_dat
);

  localparam int PPW = calc_ppw(NB_DATA, NB_PIXEL);
  localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(PPW - 1);

  logic [LW-1:0]               lane_cnt;
  logic [NB_DATA-NB_PIXEL-1:0] lanes_q;
  logic [NB_DATA-1:0]          filled;

  // New pixel enters the top lane, so after PPW pixels the first sits in lane 0.
  assign filled = {pix_dat, lanes_q};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lane_cnt <= '0;
      lanes_q  <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (pad_vld) begin
        word_vld <= 1'b1;
        word_dat <= '0;
      end else if (pix_vld) begin
        if (lane_cnt == LANE_LAST) begin
          lane_cnt <= '0;
          lanes_q  <= '0;
          word_vld <= 1'b1;
          word_dat <= filled;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
          lanes_q  <= filled[NB_DATA-1:NB_PIXEL];
        end
      end
    end
  end

endmodule

// File: rtl/frame_padder.sv
// Wraps a column-major raw frame in a one-pixel zero border and packs it into words.
// Latency: first word one cycle after i_start; optional tlast check via FRAME_PADDER_TLAST_CHECK_EN.
// Backpressure: stalls the pixel input on raw rows only; output is never throttled.
module frame_padder
  import frame_padder_pkg::*;
#(
  parameter int IMAGE_HEIGHT = 200,
  parameter int IMAGE_WIDTH  = 200,
  parameter int NB_PIXEL     = 8,
  parameter int NB_DATA      = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_PIXEL-1:0] i_s_tdata,
  input  logic                i_s_tvalid,
  input  logic                i_s_tlast,
  output logic                o_s_tready,
  output logic [NB_DATA-1:0]  o_axi_data,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_error
);

  localparam int PPW           = calc_ppw(NB_DATA, NB_PIXEL);
  localparam int WORDS_PER_COL = calc_words_per_col(IMAGE_HEIGHT, PPW);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int WW = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;

  localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FINAL = RW'(IMAGE_HEIGHT - 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 3);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_COL - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;   // body column index, 0 = padded column 1
  logic [WW-1:0] word_q;
  logic          frame_done_q;

  logic                zero_row;
  logic                s_tready;
  logic                pix_vld;
  logic [NB_PIXEL-1:0] pix_dat;
  logic                pad_vld;

  always_comb begin
    state_d  = state_q;
    zero_row = (row_q == '0) || (row_q == ROW_LAST);
    s_tready = 1'b0;
    pix_vld  = 1'b0;
    pix_dat  = '0;
    pad_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = PAD_FIRST;
      end
      PAD_FIRST: begin
        pad_vld = 1'b1;
        if (word_q == WORD_LAST) state_d = BODY;
      end
      BODY: begin
        s_tready = !zero_row;
        pix_vld  = zero_row || i_s_tvalid;
        pix_dat  = zero_row ? '0 : i_s_tdata;
        if (pix_vld && (row_q == ROW_LAST) && (col_q == COL_LAST)) state_d = PAD_LAST;
      end
      PAD_LAST: begin
        pad_vld = 1'b1;
        if (word_q == WORD_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == DONE);
      if (pad_vld) begin
        word_q <= (word_q == WORD_LAST) ? '0 : word_q + 1'b1;
      end
      if (pix_vld) begin
        if (row_q == ROW_LAST) begin
          row_q <= '0;
          col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

  assign o_s_tready   = s_tready;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = frame_done_q;

`ifdef FRAME_PADDER_TLAST_CHECK_EN
  logic err_q;
  logic final_raw;

  // The last raw pixel lives on the second-to-last row of the last body column.
  assign final_raw = (col_q == COL_LAST) && (row_q == ROW_FINAL);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && i_start) begin
      err_q <= 1'b0;
    end else if (s_tready && i_s_tvalid && (i_s_tlast != final_raw)) begin
      err_q <= 1'b1;
    end
  end

  assign o_error = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = i_s_tlast;
  assign o_error      = 1'b0;
`endif

  pixel_packer #(
    .NB_PIXEL (NB_PIXEL),
    .NB_DATA  (NB_DATA)
  ) u_packer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .pix_vld  (pix_vld),
    .pix_dat  (pix_dat),
    .pad_vld  (pad_vld),
    .word_vld (o_valid),
    .word_dat (o_axi_data)
  );

endmodule

// File: tb/tb_frame_padder.sv
// Directed bench for frame_padder with an 8x5 padded frame of 8-bit pixels in 32-bit words.
module tb_frame_padder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_s_tdata;
  logic        i_s_tvalid;
  logic        i_s_tlast;
  logic        o_s_tready;
  logic [31:0] o_axi_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_error;

  frame_padder #(
    .IMAGE_HEIGHT (8),
    .IMAGE_WIDTH  (5),
    .NB_PIXEL     (8),
    .NB_DATA      (32)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_s_tdata    (i_s_tdata),
    .i_s_tvalid   (i_s_tvalid),
    .i_s_tlast    (i_s_tlast),
    .o_s_tready   (o_s_tready),
    .o_axi_data   (o_axi_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  int          cyc = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  int          total = 0;
  int          passed = 0;
  int          failed = 0;

  logic [31:0] exp_words [10] = '{32'h00000000, 32'h00000000, 32'h03020100, 32'h00060504,
                                  32'h09080700, 32'h000C0B0A, 32'h0F0E0D00, 32'h00121110,
                                  32'h00000000, 32'h00000000};

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_valid === 1'b1) begin
      got.push_back(o_axi_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_words(input string name);
    logic [31:0] w;
    chk({name, "_count"}, 32'(got.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      chk($sformatf("%s_w%0d", name, i), w, exp_words[i]);
    end
  endtask

  // Runs one frame: raw pixel k carries value k+1; optional stall before pixel stall_at,
  // an extra i_start at cycle restart_at, tlast on pixel tlast_at, early exit after abort_words.
  task automatic run_frame(input int stall_at, input int stall_len, input int restart_at,
                           input int tlast_at, input int abort_words,
                           output int start_cyc, output int done_cyc,
                           output logic busy_all, output logic err_done);
    int   pix;
    int   stall_rem;
    logic acc;
    got.delete();
    got_cyc.delete();
    pix       = 0;
    stall_rem = stall_len;
    busy_all  = 1'b1;
    done_cyc  = -1;
    err_done  = 1'bx;
    i_start    = 1'b1;
    i_s_tvalid = 1'b0;
    step();
    i_start   = 1'b0;
    start_cyc = cyc;
    for (int c = 0; c < 200; c++) begin
      if (abort_words > 0 && got.size() >= abort_words) break;
      if (o_frame_done === 1'b1) begin
        done_cyc = cyc;
        err_done = o_error;
        break;
      end
      busy_all = busy_all & o_busy;
      if (pix == stall_at && stall_rem > 0) begin
        i_s_tvalid = 1'b0;
        stall_rem--;
      end else begin
        i_s_tvalid = (pix < 18);
      end
      i_s_tdata = 8'(pix + 1);
      i_s_tlast = (pix == tlast_at);
      i_start   = (c == restart_at);
      acc = i_s_tvalid && o_s_tready;
      step();
      if (acc) pix++;
    end
    i_start    = 1'b0;
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
  endtask

  int   s_cyc, d_cyc;
  logic busy_all, err_done;

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_s_tdata  = 8'h00;
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
    #1 i_reset = 1'b0;
    step();
    step();
    chk("reset_data",  o_axi_data,         32'h0);
    chk("reset_valid", 32'(o_valid),       32'd0);
    chk("reset_tready",32'(o_s_tready),    32'd0);
    chk("reset_busy",  32'(o_busy),        32'd0);
    chk("reset_done",  32'(o_frame_done),  32'd0);
    chk("reset_error", 32'(o_error),       32'd0);
    i_reset = 1'b1;
    repeat (4) step();
    chk("idle_no_words", 32'(got.size()), 32'd0);

    // Nominal frame
    run_frame(-1, 0, -1, 17, 0, s_cyc, d_cyc, busy_all, err_done);
    check_words("nom");
    chk("nom_first_latency", 32'((got_cyc.size() > 0) ? got_cyc[0] - s_cyc : -1), 32'd1);
    chk("nom_gap_w2_w3", 32'((got_cyc.size() > 3) ? got_cyc[3] - got_cyc[2] : -1), 32'd4);
    chk("nom_done_after_last", 32'((got_cyc.size() == 10) ? d_cyc - got_cyc[9] : -1), 32'd1);
    chk("nom_busy_in_frame", 32'(busy_all), 32'd1);
    chk("nom_busy_at_done", 32'(o_busy), 32'd0);
    chk("nom_err", 32'(err_done), 32'd0);
    step();
    chk("nom_done_one_cycle", 32'(o_frame_done), 32'd0);
    repeat (2) step();

    // Input stall of 5 cycles before p4
    run_frame(4, 5, -1, 17, 0, s_cyc, d_cyc, busy_all, err_done);
    check_words("stall");
    chk("stall_gap_w2_w3", 32'((got_cyc.size() > 3) ? got_cyc[3] - got_cyc[2] : -1), 32'd9);
    repeat (2) step();

    // Stray i_start in BODY
    run_frame(-1, 0, 10, 17, 0, s_cyc, d_cyc, busy_all, err_done);
    check_words("restart");
    repeat (5) step();
    chk("restart_no_extra", 32'(got.size()), 32'd10);

    // Reset while the 4th word is on the output
    run_frame(-1, 0, -1, 17, 3, s_cyc, d_cyc, busy_all, err_done);
    i_s_tvalid = 1'b1;
    repeat (3) step();
    chk("rst_pre_valid", 32'(o_valid), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_data",   o_axi_data,        32'h0);
    chk("rst_valid",  32'(o_valid),      32'd0);
    chk("rst_tready", 32'(o_s_tready),   32'd0);
    chk("rst_busy",   32'(o_busy),       32'd0);
    chk("rst_done",   32'(o_frame_done), 32'd0);
    chk("rst_error",  32'(o_error),      32'd0);
    i_s_tvalid = 1'b0;
    step();
    step();
    i_reset = 1'b1;
    got.delete();
    repeat (6) step();
    chk("rst_no_words", 32'(got.size()), 32'd0);
    chk("rst_idle_busy", 32'(o_busy), 32'd0);
    run_frame(-1, 0, -1, 17, 0, s_cyc, d_cyc, busy_all, err_done);
    check_words("after_rst");
    repeat (2) step();

    // tlast on p10 instead of p17
    run_frame(-1, 0, -1, 10, 0, s_cyc, d_cyc, busy_all, err_done);
`ifdef FRAME_PADDER_TLAST_CHECK_EN
    chk("tlast_bad_err_at_done", 32'(err_done), 32'd1);
    step();
    chk("tlast_bad_err_sticky", 32'(o_error), 32'd1);
    run_frame(-1, 0, -1, 17, 0, s_cyc, d_cyc, busy_all, err_done);
    chk("tlast_good_err", 32'(err_done), 32'd0);
`else
    chk("tlast_ignored_err", 32'(err_done), 32'd0);
`endif
    check_words("tlast");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_padder.md
FRAME_PADDER -- requirements
Module: frame_padder

Interface
REQ-001 SHALL have parameter IMAGE_HEIGHT, default 200, meaning padded column height in pixels; a multiple of NB_DATA/NB_PIXEL.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 200, meaning padded frame width in columns.
REQ-003 SHALL have parameter NB_PIXEL, default 8, meaning bits per pixel.
REQ-004 SHALL have parameter NB_DATA, default 32, meaning output word width, which holds PPW = NB_DATA/NB_PIXEL pixels.
REQ-005 SHALL have one clock and one asynchronous, active-low reset; the clock is `i_clk` and the reset is `i_reset`, port list below:
  i_clk  in  1  clock, rising edge
  i_reset  in  1  asynchronous, active-low reset
  i_start  in  1  one-cycle pulse that starts one frame
  i_s_tdata  in  NB_PIXEL  raw (unpadded) pixel, column-major, top row first
  i_s_tvalid  in  1  raw pixel valid
  i_s_tlast  in  1  last raw pixel of the frame
  o_s_tready  out  1  pixel accepted when high together with i_s_tvalid
  o_axi_data  out  NB_DATA  packed padded word, lane 0 in bits [NB_PIXEL-1:0] = topmost row
  o_valid  out  1  o_axi_data valid, one cycle per word; drives the subframe buffer's valid input
  o_busy  out  1  frame in progress
  o_frame_done  out  1  one-cycle pulse after the last word
  o_error  out  1  sticky tlast-mismatch flag

Function
REQ-006 SHALL implement FSM states IDLE, PAD_FIRST, BODY, PAD_LAST, DONE.
REQ-007 SHALL move IDLE->PAD_FIRST on i_start; i_start SHALL be ignored in every other state.
REQ-008 SHALL, in PAD_FIRST and PAD_LAST, emit IMAGE_HEIGHT/PPW all-zero words, one per cycle, then move to BODY and DONE respectively.
REQ-009 SHALL, in BODY, walk rows 0..IMAGE_HEIGHT-1 of columns 1..IMAGE_WIDTH-2; rows 0 and IMAGE_HEIGHT-1 SHALL insert a zero pixel without consuming input; other rows SHALL consume one raw pixel.
REQ-010 SHALL drive o_s_tready high only in BODY on a raw row; the row counter SHALL advance on zero rows, or on raw rows only when i_s_tvalid && o_s_tready (stall otherwise).
REQ-011 SHALL drive o_valid from a register, one cycle after the PPW-th lane of a word is filled; o_axi_data SHALL be registered with o_valid and held otherwise.
REQ-012 SHALL move BODY->PAD_LAST after row IMAGE_HEIGHT-1 of column IMAGE_WIDTH-2; the row counter SHALL wrap to 0 at each column end.
REQ-013 SHALL have DONE last one cycle, pulse o_frame_done, then return to IDLE.
REQ-014 SHALL emit exactly IMAGE_WIDTH*IMAGE_HEIGHT/PPW words per frame; o_valid is never throttled (downstream has no backpressure).
REQ-015 SHALL assert o_busy in every state except IDLE.

Reset
REQ-016 SHALL, on i_reset low at any time including mid-frame, immediately force IDLE, clear all counters and lanes, and drive o_axi_data=0, o_valid=0, o_s_tready=0, o_busy=0, o_frame_done=0, o_error=0.
REQ-017 SHALL, after reset release, emit no word until the next i_start.

Configuration
REQ-018 SHALL, with macro FRAME_PADDER_TLAST_CHECK_EN defined, set o_error when a pixel is accepted with i_s_tlast high that is not the final raw pixel, or the final raw pixel is accepted with i_s_tlast low; o_error SHALL be cleared by i_start in IDLE.
REQ-019 SHALL, without the macro, ignore i_s_tlast and tie o_error to 0; all ports SHALL remain present.

Structure
REQ-020 SHALL place the FSM state type and the derived constants PPW and WORDS_PER_COL in shared package frame_padder_pkg.
REQ-021 SHALL put lane fill/shift and output registering in one sub-module, pixel_packer.

Verification (IMAGE_HEIGHT=8, IMAGE_WIDTH=5, NB_PIXEL=8, NB_DATA=32; raw pixels p0..p17 = 0x01..0x12)
REQ-022 Nominal frame, i_s_tvalid always high -> 10 words: 0x00000000 x2, 0x03020100, 0x00060504, 0x09080700, 0x000C0B0A, 0x0F0E0D00, 0x0012110F+1 i.e. 0x00121110, 0x00000000 x2; then o_frame_done one cycle.
REQ-023 i_s_tvalid low for 5 cycles before p4 -> same words in the same order; o_valid gap of 5 cycles; no words dropped or duplicated.
REQ-024 i_start pulsed again mid-BODY -> ignored; word count stays 10.
REQ-025 i_reset low during the 4th word -> all outputs 0 within the reset assertion; next i_start gives a full correct 10-word frame.
REQ-026 With FRAME_PADDER_TLAST_CHECK_EN: i_s_tlast on p10 -> o_error=1 and stays high through o_frame_done; next i_start clears it; i_s_tlast only on p17 -> o_error=0.
